blowfish_expand_key: RTL and testbench

- Key-schedule sequencer that sits directly upstream of the Feistel round engine.
- Phase 1 XORs the 18-word P-array in SRAM with the cyclically repeated key.
- Phase 2 runs 521 chained Feistel encryptions. L/R start at zero and are optionally salt-XORed. Each result pair overwrites P[0..17] and then S[0..1023] in order, producing the expanded Blowfish state that bcrypt rounds consume.

---
 rtl/blowfish_expand_key_if.sv | 41 ++++
 rtl/blowfish_expand_key.sv | 208 ++++++++++++++++++++
 tb/tb_blowfish_expand_key.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blowfish_expand_key_if.sv
// Signal bundle between the Blowfish key-schedule sequencer and its environment:
// start/status, key-word lookup, SRAM port A and the Feistel round engine.
interface blowfish_expand_key_if;
  logic         start;
  logic         salt_en;
  logic [127:0] salt;
  logic [4:0]   key_len;
  logic [4:0]   key_idx;
  logic [31:0]  key_word;
  logic         sram_sel;
  logic [31:0]  data_out;
  logic [31:0]  data_in;
  logic [11:0]  addr;
  logic         cs_l;
  logic         we_l;
  logic         oe_l;
  logic         fs_start;
  logic [31:0]  fs_L;
  logic [31:0]  fs_R;
  logic [31:0]  fs_resultL;
  logic [31:0]  fs_resultR;
  logic         fs_done;
  logic         busy;
  logic         done;

  // Sequencer side.
  modport master (
    input  start, salt_en, salt, key_len, key_word, data_out,
           fs_resultL, fs_resultR, fs_done,
    output key_idx, sram_sel, data_in, addr, cs_l, we_l, oe_l,
           fs_start, fs_L, fs_R, busy, done
  );

  // Environment side: requester, key store, SRAM and Feistel engine.
  modport slave (
    output start, salt_en, salt, key_len, key_word, data_out,
           fs_resultL, fs_resultR, fs_done,
    input  key_idx, sram_sel, data_in, addr, cs_l, we_l, oe_l,
           fs_start, fs_L, fs_R, busy, done
  );
endinterface

// File: rtl/blowfish_expand_key.sv
// Blowfish key-schedule sequencer: XORs the key into the P-array, then runs 521 chained
// Feistel encryptions whose outputs overwrite P[0..17] and S[0..1023] in order.
module blowfish_expand_key #(
  parameter int P_ARRAY_OFFSET = 4000,
  parameter int S_BOX_OFFSET   = 0,
  parameter int NUM_WORDS      = 1042
) (
  input  logic                 clk,
  input  logic                 reset_l,
  blowfish_expand_key_if.master bus
);

  localparam int          P_WORDS = 18;
  localparam logic [4:0]  P_LAST  = 5'(P_WORDS - 1);
  localparam logic [10:0] W_LAST  = 11'(NUM_WORDS - 1);
  localparam logic [11:0] P_BASE  = 12'(P_ARRAY_OFFSET);
  localparam logic [11:0] S_BASE  = 12'(S_BOX_OFFSET);

  typedef enum logic [2:0] {
    IDLE, KX_RD, KX_WR, ENC_START, ENC_WAIT, WR_L, WR_R, DONE
  } state_e;

  state_e        state_q, state_d;
  logic          salt_en_q, salt_en_d;
  logic [127:0]  salt_q, salt_d;
  logic [4:0]    key_len_q, key_len_d;
  logic [4:0]    p_idx_q, p_idx_d;
  logic [4:0]    k_idx_q, k_idx_d;
  logic [10:0]   w_idx_q, w_idx_d;
  logic [31:0]   l_q, l_d;
  logic [31:0]   r_q, r_d;
  logic [31:0]   fs_l_q, fs_l_d;
  logic [31:0]   fs_r_q, fs_r_d;
  logic          salt_ph_q, salt_ph_d;

  logic [4:0]    key_len_clamped;
  logic [31:0]   salt_l, salt_r, enc_l, enc_r;
  logic [11:0]   p_addr, w_addr;

  // A zero or oversized key length means "use all 18 key words".
  assign key_len_clamped = (bus.key_len == 5'd0 || bus.key_len > 5'(P_WORDS))
                           ? 5'(P_WORDS) : bus.key_len;

  always_comb begin
    salt_l = salt_ph_q ? salt_q[63:32] : salt_q[127:96];
    salt_r = salt_ph_q ? salt_q[31:0]  : salt_q[95:64];
    enc_l  = salt_en_q ? (l_q ^ salt_l) : l_q;
    enc_r  = salt_en_q ? (r_q ^ salt_r) : r_q;
  end

  // Phase-2 word w lands in the P-array first, then runs through the contiguous S-boxes.
  always_comb begin
    p_addr = P_BASE + {7'd0, p_idx_q};
    if (w_idx_q < 11'(P_WORDS)) w_addr = P_BASE + {1'b0, w_idx_q};
    else                        w_addr = S_BASE + ({1'b0, w_idx_q} - 12'(P_WORDS));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.start) state_d = KX_RD;
      KX_RD:     state_d = KX_WR;
      KX_WR:     state_d = (p_idx_q == P_LAST) ? ENC_START : KX_RD;
      ENC_START: state_d = ENC_WAIT;
      ENC_WAIT:  if (bus.fs_done) state_d = WR_L;
      WR_L:      state_d = WR_R;
      WR_R:      state_d = (w_idx_q == W_LAST) ? DONE : ENC_START;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    salt_en_d = salt_en_q;
    salt_d    = salt_q;
    key_len_d = key_len_q;
    p_idx_d   = p_idx_q;
    k_idx_d   = k_idx_q;
    w_idx_d   = w_idx_q;
    l_d       = l_q;
    r_d       = r_q;
    fs_l_d    = fs_l_q;
    fs_r_d    = fs_r_q;
    salt_ph_d = salt_ph_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          salt_en_d = bus.salt_en;
          salt_d    = bus.salt;
          key_len_d = key_len_clamped;
          p_idx_d   = '0;
          k_idx_d   = '0;
          w_idx_d   = '0;
          l_d       = '0;
          r_d       = '0;
          salt_ph_d = 1'b0;
        end
      end
      KX_WR: begin
        k_idx_d = (k_idx_q + 5'd1 == key_len_q) ? 5'd0 : k_idx_q + 5'd1;
        if (p_idx_q != P_LAST) p_idx_d = p_idx_q + 5'd1;
      end
      ENC_START: begin
        // Capture the launched inputs so they stay put while the engine works.
        fs_l_d    = enc_l;
        fs_r_d    = enc_r;
        salt_ph_d = ~salt_ph_q;
      end
      ENC_WAIT: begin
        if (bus.fs_done) begin
          l_d = bus.fs_resultL;
          r_d = bus.fs_resultR;
        end
      end
      WR_L: w_idx_d = w_idx_q + 11'd1;
      WR_R: if (w_idx_q != W_LAST) w_idx_d = w_idx_q + 11'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      salt_en_q <= 1'b0;
      salt_q    <= '0;
      key_len_q <= '0;
      p_idx_q   <= '0;
      k_idx_q   <= '0;
      w_idx_q   <= '0;
      l_q       <= '0;
      r_q       <= '0;
      fs_l_q    <= '0;
      fs_r_q    <= '0;
      salt_ph_q <= 1'b0;
    end else begin
      salt_en_q <= salt_en_d;
      salt_q    <= salt_d;
      key_len_q <= key_len_d;
      p_idx_q   <= p_idx_d;
      k_idx_q   <= k_idx_d;
      w_idx_q   <= w_idx_d;
      l_q       <= l_d;
      r_q       <= r_d;
      fs_l_q    <= fs_l_d;
      fs_r_q    <= fs_r_d;
      salt_ph_q <= salt_ph_d;
    end
  end

  always_comb begin
    bus.busy     = (state_q != IDLE) && (state_q != DONE);
    bus.done     = 1'b0;
    bus.fs_start = 1'b0;
    bus.fs_L     = fs_l_q;
    bus.fs_R     = fs_r_q;
    bus.sram_sel = 1'b0;
    bus.cs_l     = 1'b1;
    bus.we_l     = 1'b1;
    bus.oe_l     = 1'b0;
    bus.addr     = '0;
    bus.data_in  = '0;
    bus.key_idx  = '0;
    case (state_q)
      KX_RD: begin
        bus.sram_sel = 1'b1;
        bus.cs_l     = 1'b0;
        bus.addr     = p_addr;
      end
      KX_WR: begin
        bus.sram_sel = 1'b1;
        bus.cs_l     = 1'b0;
        bus.we_l     = 1'b0;
        bus.addr     = p_addr;
        bus.data_in  = bus.data_out ^ bus.key_word;
        bus.key_idx  = k_idx_q;
      end
      ENC_START: begin
        bus.fs_start = 1'b1;
        bus.fs_L     = enc_l;
        bus.fs_R     = enc_r;
      end
      WR_L: begin
        bus.sram_sel = 1'b1;
        bus.cs_l     = 1'b0;
        bus.we_l     = 1'b0;
        bus.addr     = w_addr;
        bus.data_in  = l_q;
      end
      WR_R: begin
        bus.sram_sel = 1'b1;
        bus.cs_l     = 1'b0;
        bus.we_l     = 1'b0;
        bus.addr     = w_addr;
        bus.data_in  = r_q;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_blowfish_expand_key.sv
// Directed bench for blowfish_expand_key: SRAM model, key store and a Feistel stub that
// returns (L+1, R+2) three cycles after each start.
`timescale 1ns/1ps
module tb_blowfish_expand_key;

  localparam logic [31:0] PI [18] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344, 32'hA4093822, 32'h299F31D0,
    32'h082EFA98, 32'hEC4E6C89, 32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917, 32'h9216D5D9, 32'h8979FB1B
  };

  logic clk = 1'b0;
  logic reset_l;
  always #5 clk = ~clk;

  blowfish_expand_key_if bus_if ();
  blowfish_expand_key dut (.clk(clk), .reset_l(reset_l), .bus(bus_if));

  int tests_run = 0;
  int fails     = 0;

  logic [31:0] mem [4096];
  logic [31:0] rd_q;
  logic        pre_req;
  logic [31:0] key_rom [32];
  int          wr_count = 0;
  logic [4:0]  klog [16384];
  logic [11:0] alog [16384];

  int          n_starts = 0;
  logic [31:0] fsl_log [4096];
  logic [31:0] fsr_log [4096];
  int          done_cnt = 0;

  logic        stub_en;
  logic        inj_done;
  logic        stub_busy = 1'b0;
  logic        stub_done = 1'b0;
  int          stub_cnt  = 0;
  logic [31:0] stub_l = '0, stub_r = '0;

  assign bus_if.data_out   = rd_q;
  assign bus_if.key_word   = key_rom[bus_if.key_idx];
  assign bus_if.fs_done    = stub_done | inj_done;
  assign bus_if.fs_resultL = stub_l;
  assign bus_if.fs_resultR = stub_r;

  function automatic logic [31:0] preload_word(input int a);
    if (a >= 4000 && a < 4018) return PI[a - 4000];
    return 32'hDEAD_BEEF;
  endfunction

  // SRAM: synchronous read (data the cycle after the read strobe), write on the edge.
  always @(posedge clk) begin
    if (pre_req) begin
      for (int a = 0; a < 4096; a++) mem[a] <= preload_word(a);
    end else if (bus_if.sram_sel && !bus_if.cs_l) begin
      if (!bus_if.we_l) begin
        mem[bus_if.addr] <= bus_if.data_in;
        if (wr_count < 16384) begin
          klog[wr_count] <= bus_if.key_idx;
          alog[wr_count] <= bus_if.addr;
        end
        wr_count <= wr_count + 1;
      end else begin
        rd_q <= mem[bus_if.addr];
      end
    end
  end

  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (!reset_l) begin
      stub_busy <= 1'b0;
    end else if (bus_if.fs_start) begin
      if (n_starts < 4096) begin
        fsl_log[n_starts] <= bus_if.fs_L;
        fsr_log[n_starts] <= bus_if.fs_R;
      end
      n_starts <= n_starts + 1;
      if (stub_en) begin
        stub_busy <= 1'b1;
        stub_cnt  <= 3;
        stub_l    <= bus_if.fs_L + 32'd1;
        stub_r    <= bus_if.fs_R + 32'd2;
      end
    end else if (stub_busy) begin
      if (stub_cnt == 1) begin
        stub_done <= 1'b1;
        stub_busy <= 1'b0;
      end
      stub_cnt <= stub_cnt - 1;
    end
  end

  always @(posedge clk) if (bus_if.done) done_cnt <= done_cnt + 1;

  // Expected image after a full run with the (L+1, R+2) stub and no salt:
  // encryption n (1-based) yields L=n, R=2n.
  function automatic int phase2_mismatches();
    int bad, n, a;
    logic [31:0] e;
    bad = 0;
    for (int w = 0; w < 1042; w++) begin
      n = w / 2 + 1;
      e = (w % 2 == 0) ? 32'(n) : 32'(2 * n);
      a = (w < 18) ? 4000 + w : w - 18;
      if (mem[a] !== e) bad++;
    end
    return bad;
  endfunction

  function automatic int p_mismatches(input int eff_len);
    int bad;
    bad = 0;
    for (int i = 0; i < 18; i++)
      if (mem[4000 + i] !== (PI[i] ^ key_rom[i % eff_len])) bad++;
    return bad;
  endfunction

  task automatic apply_reset();
    reset_l = 1'b0;
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic preload();
    @(negedge clk);
    pre_req = 1'b1;
    @(negedge clk);
    pre_req = 1'b0;
  endtask

  // Returns at the falling edge right after the start request was accepted.
  task automatic do_start(input logic se, input logic [127:0] s, input logic [4:0] kl);
    @(negedge clk);
    bus_if.salt_en = se;
    bus_if.salt    = s;
    bus_if.key_len = kl;
    bus_if.start   = 1'b1;
    @(negedge clk);
    bus_if.start   = 1'b0;
    bus_if.salt_en = 1'b0;
    bus_if.salt    = '0;
    bus_if.key_len = 5'd7;
  endtask

  task automatic wait_fs_start(output int n);
    n = 0;
    while (!bus_if.fs_start && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus_if.done && n < 20000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus_if.busy, bus_if.done, bus_if.fs_start, bus_if.sram_sel,
         bus_if.cs_l, bus_if.we_l, bus_if.oe_l} !== 7'b0000110) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0000110", {bus_if.busy, bus_if.done,
               bus_if.fs_start, bus_if.sram_sel, bus_if.cs_l, bus_if.we_l, bus_if.oe_l});
    end
    tests_run++;
    if ({bus_if.addr, bus_if.data_in, bus_if.key_idx, bus_if.fs_L, bus_if.fs_R} !== '0) begin
      fails++;
      $display("FAIL reset_data: addr=%h data_in=%h key_idx=%0d fs_L=%h fs_R=%h want all 0",
               bus_if.addr, bus_if.data_in, bus_if.key_idx, bus_if.fs_L, bus_if.fs_R);
    end
    reset_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_phase1_inversion();
    int n, wb, sb;
    stub_en = 1'b0;
    for (int i = 0; i < 32; i++) key_rom[i] = 32'hFFFF_FFFF;
    preload();
    wb = wr_count;
    sb = n_starts;
    do_start(1'b0, '0, 5'd1);
    tests_run++;
    if (bus_if.busy !== 1'b1) begin
      fails++;
      $display("FAIL p1_busy_rise: busy=%b want 1", bus_if.busy);
    end
    wait_fs_start(n);
    tests_run++;
    if (n != 36) begin
      fails++;
      $display("FAIL p1_length: fs_start after %0d cycles want 36", n);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if ({bus_if.busy, bus_if.cs_l, bus_if.fs_L, bus_if.fs_R} !== {1'b1, 1'b1, 64'd0}) begin
      fails++;
      $display("FAIL p1_enc_wait: busy=%b cs_l=%b fs_L=%h fs_R=%h want 1 1 0 0",
               bus_if.busy, bus_if.cs_l, bus_if.fs_L, bus_if.fs_R);
    end
    tests_run++;
    if (mem[4000] !== 32'hDBC0_9577) begin
      fails++;
      $display("FAIL p1_p0: got %h want dbc09577", mem[4000]);
    end
    tests_run++;
    if (p_mismatches(1) != 0 || wr_count - wb != 18 || n_starts - sb != 1) begin
      fails++;
      $display("FAIL p1_image: bad_words=%0d writes=%0d starts=%0d want 0 18 1",
               p_mismatches(1), wr_count - wb, n_starts - sb);
    end
    apply_reset();
  endtask

  task automatic test_unsalted();
    int n, wb, sb, db;
    stub_en = 1'b1;
    for (int i = 0; i < 32; i++) key_rom[i] = {8'(i + 1), 24'h5A5A5A};
    preload();
    wb = wr_count;
    sb = n_starts;
    db = done_cnt;
    do_start(1'b0, '0, 5'd18);
    wait_done(n);
    tests_run++;
    if ({bus_if.done, bus_if.busy} !== 2'b10) begin
      fails++;
      $display("FAIL unsalted_done: done=%b busy=%b after %0d cycles want 1 0",
               bus_if.done, bus_if.busy, n);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus_if.done !== 1'b0 || done_cnt - db != 1) begin
      fails++;
      $display("FAIL unsalted_pulse: done=%b pulses=%0d want 0 1", bus_if.done, done_cnt - db);
    end
    tests_run++;
    if (wr_count - wb != 1060 || n_starts - sb != 521) begin
      fails++;
      $display("FAIL unsalted_counts: writes=%0d starts=%0d want 1060 521",
               wr_count - wb, n_starts - sb);
    end
    tests_run++;
    if ({mem[4000], mem[4001], mem[4002], mem[4003]} !== {32'd1, 32'd2, 32'd2, 32'd4}) begin
      fails++;
      $display("FAIL unsalted_first: P0..3=%h %h %h %h want 1 2 2 4",
               mem[4000], mem[4001], mem[4002], mem[4003]);
    end
    tests_run++;
    if ({mem[1022], mem[1023]} !== {32'd521, 32'd1042}) begin
      fails++;
      $display("FAIL unsalted_last: S1022=%0d S1023=%0d want 521 1042", mem[1022], mem[1023]);
    end
    tests_run++;
    if (phase2_mismatches() != 0) begin
      fails++;
      $display("FAIL unsalted_image: %0d bad words want 0", phase2_mismatches());
    end
  endtask

  task automatic test_salted();
    int n, sb;
    stub_en = 1'b1;
    preload();
    sb = n_starts;
    do_start(1'b1, 128'h00000010_00000020_00000030_00000040, 5'd18);
    wait_fs_start(n);
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus_if.fs_L, bus_if.fs_R} !== {32'h10, 32'h20}) begin
      fails++;
      $display("FAIL salt_hold: fs_L=%h fs_R=%h want 10 20", bus_if.fs_L, bus_if.fs_R);
    end
    n = 0;
    while (n_starts - sb < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if ({fsl_log[sb], fsr_log[sb]} !== {32'h10, 32'h20}) begin
      fails++;
      $display("FAIL salt_enc1: fs_L=%h fs_R=%h want 10 20", fsl_log[sb], fsr_log[sb]);
    end
    tests_run++;
    if ({fsl_log[sb + 1], fsr_log[sb + 1]} !== {32'h21, 32'h62}) begin
      fails++;
      $display("FAIL salt_enc2: fs_L=%h fs_R=%h want 21 62", fsl_log[sb + 1], fsr_log[sb + 1]);
    end
    tests_run++;
    if ({fsl_log[sb + 2], fsr_log[sb + 2]} !== {32'h32, 32'h44}) begin
      fails++;
      $display("FAIL salt_enc3: fs_L=%h fs_R=%h want 32 44", fsl_log[sb + 2], fsr_log[sb + 2]);
    end
    apply_reset();
  endtask

  task automatic test_key_len();
    logic [4:0]  lens [4];
    int          effs [4];
    logic [31:0] ref18 [18];
    int n, wb, bad_ref, bad_idx;
    lens = '{5'd18, 5'd0, 5'd25, 5'd5};
    effs = '{18, 18, 18, 5};
    stub_en = 1'b0;
    for (int i = 0; i < 32; i++) key_rom[i] = {8'(i + 1), 24'h5A5A5A};
    for (int t = 0; t < 4; t++) begin
      preload();
      wb = wr_count;
      do_start(1'b0, '0, lens[t]);
      wait_fs_start(n);
      @(negedge clk);
      bad_ref = 0;
      bad_idx = 0;
      for (int i = 0; i < 18; i++) begin
        if (t == 0) ref18[i] = mem[4000 + i];
        else if (t < 3 && mem[4000 + i] !== ref18[i]) bad_ref++;
        if (klog[wb + i] !== 5'(i % effs[t])) bad_idx++;
      end
      tests_run++;
      if (n != 36 || p_mismatches(effs[t]) != 0 || bad_ref != 0) begin
        fails++;
        $display("FAIL key_len_%0d: cycles=%0d bad_words=%0d differs_from_18=%0d want 36 0 0",
                 lens[t], n, p_mismatches(effs[t]), bad_ref);
      end
      tests_run++;
      if (bad_idx != 0) begin
        fails++;
        $display("FAIL key_idx_seq_%0d: %0d wrong key_idx values want 0", lens[t], bad_idx);
      end
      apply_reset();
    end
  endtask

  task automatic test_reset_mid();
    int n, wb, sb;
    stub_en = 1'b1;
    preload();
    sb = n_starts;
    do_start(1'b0, '0, 5'd18);
    n = 0;
    while (n_starts - sb < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (bus_if.fs_L !== 32'd99 || bus_if.busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_enc100: fs_L=%0d busy=%b want 99 1", bus_if.fs_L, bus_if.busy);
    end
    reset_l = 1'b0;
    #1;
    tests_run++;
    if ({bus_if.busy, bus_if.done, bus_if.fs_start, bus_if.sram_sel, bus_if.cs_l,
         bus_if.we_l, bus_if.oe_l, bus_if.addr, bus_if.data_in, bus_if.key_idx,
         bus_if.fs_L, bus_if.fs_R} !== {7'b0000110, 12'd0, 32'd0, 5'd0, 64'd0}) begin
      fails++;
      $display("FAIL mid_reset_outputs: busy=%b sram_sel=%b cs_l=%b we_l=%b fs_L=%h want reset values",
               bus_if.busy, bus_if.sram_sel, bus_if.cs_l, bus_if.we_l, bus_if.fs_L);
    end
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    stub_en = 1'b0;
    preload();
    wb = wr_count;
    do_start(1'b0, '0, 5'd18);
    wait_fs_start(n);
    @(negedge clk);
    tests_run++;
    if (n != 36 || wr_count - wb != 18 || alog[wb] !== 12'd4000 || alog[wb + 17] !== 12'd4017
        || p_mismatches(18) != 0) begin
      fails++;
      $display("FAIL mid_restart: cycles=%0d writes=%0d first=%0d last=%0d bad=%0d want 36 18 4000 4017 0",
               n, wr_count - wb, alog[wb], alog[wb + 17], p_mismatches(18));
    end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    int n, wb, sb, db;
    stub_en = 1'b1;
    preload();
    wb = wr_count;
    sb = n_starts;
    db = done_cnt;
    do_start(1'b0, '0, 5'd18);
    n = 0;
    while (!(bus_if.sram_sel && !bus_if.cs_l && !bus_if.we_l) && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n >= 50) begin
      fails++;
      $display("FAIL b2b_find_kx_wr: no key write seen within %0d cycles", n);
    end
    inj_done       = 1'b1;
    bus_if.start   = 1'b1;
    bus_if.salt_en = 1'b1;
    bus_if.salt    = '1;
    bus_if.key_len = 5'd3;
    @(negedge clk);
    inj_done       = 1'b0;
    bus_if.start   = 1'b0;
    n = 0;
    while (n_starts - sb < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start   = 1'b0;
    bus_if.salt_en = 1'b0;
    bus_if.salt    = '0;
    wait_done(n);
    repeat (3) @(negedge clk);
    tests_run++;
    if (done_cnt - db != 1 || wr_count - wb != 1060 || n_starts - sb != 521) begin
      fails++;
      $display("FAIL b2b_counts: done=%0d writes=%0d starts=%0d want 1 1060 521",
               done_cnt - db, wr_count - wb, n_starts - sb);
    end
    tests_run++;
    if (phase2_mismatches() != 0) begin
      fails++;
      $display("FAIL b2b_image: %0d bad words want 0", phase2_mismatches());
    end
  endtask

  initial begin
    reset_l        = 1'b0;
    pre_req        = 1'b0;
    stub_en        = 1'b0;
    inj_done       = 1'b0;
    bus_if.start   = 1'b0;
    bus_if.salt_en = 1'b0;
    bus_if.salt    = '0;
    bus_if.key_len = 5'd0;
    for (int i = 0; i < 32; i++) key_rom[i] = '0;

    test_reset();
    test_phase1_inversion();
    test_unsalted();
    test_salted();
    test_key_len();
    test_reset_mid();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
